// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed driver for the 8-digit 7-segment display. Hex nibbles and
//   the enable/decimal-point masks are captured into shadow registers on a
//   load strobe. They are promoted to the active registers only at a frame
//   boundary, and the active set is then scanned one digit per slot.
//   Segment map: seg[7:1] = a..g, seg[0] = dp. All outputs are active-high.
//
//   Optional feature macro: SEG_SCAN_BLINK_EN
//     This macro adds the blink_en port and a blink phase that toggles every
//     256 frames. While the phase is 1, digits flagged in blink_en are blanked.
//
// Ports
//   clk         in   1   system clock
//   rst         in   1   synchronous, active-high reset
//   load        in   1   strobe; captures digits/dig_en/dp_en (and blink_en)
//   digits      in   32  nibble i = digits[4i+3:4i]
//   dig_en      in   8   per-digit display enable
//   dp_en       in   8   per-digit decimal point
//   blink_en    in   8   per-digit blink mask (SEG_SCAN_BLINK_EN only)
//   seg_out     out  8   segment pattern for the selected digit
//   an_out      out  8   one-hot digit select
//   frame_done  out  1   pulse on the last cycle of the final digit slot

module seg_scan_driver #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int SLOT_HZ    = 1_000,
    parameter int NUM_DIGITS = 8,
    parameter int GUARD_CYC  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] digits,
    input  logic [7:0]  dig_en,
    input  logic [7:0]  dp_en,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [7:0]  blink_en,
`endif
    output logic [7:0]  seg_out,
    output logic [7:0]  an_out,
    output logic        frame_done
);

    localparam int DIV   = CLK_HZ / SLOT_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DIV - 2);
    localparam logic [CNT_W-1:0] GUARD    = CNT_W'(GUARD_CYC);
    localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);
    // Digits above NUM_DIGITS are never selected; masking them at capture
    // keeps their enables permanently clear.
    localparam logic [7:0]       DIG_MASK = 8'((1 << NUM_DIGITS) - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;

    logic [31:0] sh_digits, act_digits;
    logic [7:0]  sh_dig_en, act_dig_en;
    logic [7:0]  sh_dp_en,  act_dp_en;

    logic [7:0] seg_next;
    logic [7:0] an_next;
    logic       frame_done_next;
    logic       blanked;
    logic [3:0] nibble;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'h0: pat = 8'hFC;
            4'h1: pat = 8'h60;
            4'h2: pat = 8'hDA;
            4'h3: pat = 8'hF2;
            4'h4: pat = 8'h66;
            4'h5: pat = 8'hB6;
            4'h6: pat = 8'hBE;
            4'h7: pat = 8'hE0;
            4'h8: pat = 8'hFE;
            4'h9: pat = 8'hE6;
            4'hA: pat = 8'hEE;
            4'hB: pat = 8'h3E;
            4'hC: pat = 8'h9C;
            4'hD: pat = 8'h7A;
            4'hE: pat = 8'h9E;
            default: pat = 8'h8E;
        endcase
        return pat;
    endfunction

    // Slot counter and digit index: one slot of DIV cycles per digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow capture on load. Promotion to the active set happens only while
    // frame_done is high. A load on that same cycle bypasses the shadow, so
    // the value it carries is not lost for a whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_digits  <= '0;
            sh_dig_en  <= '0;
            sh_dp_en   <= '0;
            act_digits <= '0;
            act_dig_en <= '0;
            act_dp_en  <= '0;
        end else begin
            if (load) begin
                sh_digits <= digits;
                sh_dig_en <= dig_en & DIG_MASK;
                sh_dp_en  <= dp_en & DIG_MASK;
            end
            if (frame_done) begin
                act_digits <= load ? digits : sh_digits;
                act_dig_en <= load ? (dig_en & DIG_MASK) : sh_dig_en;
                act_dp_en  <= load ? (dp_en & DIG_MASK) : sh_dp_en;
            end
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    logic [7:0] sh_blink, act_blink;
    logic [7:0] blink_frames;
    logic       blink_phase;

    // The blink mask is double-buffered in the same way as dp_en. The phase
    // toggles when the 8-bit frame count wraps, which is every 256 frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_blink     <= '0;
            act_blink    <= '0;
            blink_frames <= '0;
            blink_phase  <= 1'b0;
        end else begin
            if (load) begin
                sh_blink <= blink_en & DIG_MASK;
            end
            if (frame_done) begin
                act_blink    <= load ? (blink_en & DIG_MASK) : sh_blink;
                blink_frames <= blink_frames + 8'd1;
                if (blink_frames == 8'hFF) begin
                    blink_phase <= ~blink_phase;
                end
            end
        end
    end

    assign blanked = blink_phase & act_blink[idx];
`else
    assign blanked = 1'b0;
`endif

    assign nibble = act_digits[{idx, 2'b00} +: 4];

    // The next output pattern is decoded from the current counter state. It
    // reaches the pins one cycle later, and the guard window at the start of
    // each slot hides that one-cycle lag.
    always_comb begin
        seg_next        = 8'h00;
        an_next         = 8'h00;
        frame_done_next = (cnt == CNT_PRE) && (idx == IDX_LAST);
        if ((cnt >= GUARD) && act_dig_en[idx] && !blanked) begin
            an_next  = 8'h01 << idx;
            seg_next = hex_to_seg(nibble) | {7'b0, act_dp_en[idx]};
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_out    <= 8'h00;
            an_out     <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            seg_out    <= seg_next;
            an_out     <= an_next;
            frame_done <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver
//   Self-checking bench for seg_scan_driver. It runs at DIV=10 with 8 digits
//   and GUARD_CYC=2. A behavioural model tracks how many cycles have passed
//   since reset, derives the slot, digit and frame from that count, and
//   predicts seg_out, an_out and frame_done every cycle.

module tb_seg_scan_driver;

    localparam int CLK_HZ     = 1000;
    localparam int SLOT_HZ    = 100;
    localparam int NUM_DIGITS = 8;
    localparam int GUARD_CYC  = 2;
    localparam int DIV        = CLK_HZ / SLOT_HZ;
    localparam int FRAME      = DIV * NUM_DIGITS;
`ifdef SEG_SCAN_BLINK_EN
    localparam bit BLINK_BUILD = 1'b1;
`else
    localparam bit BLINK_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] digits;
    logic [7:0]  dig_en;
    logic [7:0]  dp_en;
    logic [7:0]  blink_en;
    logic [7:0]  seg_out;
    logic [7:0]  an_out;
    logic        frame_done;

    int tests_run    = 0;
    int tests_failed = 0;

    // Current input values, held between loads.
    logic [31:0] cur_dig;
    logic [7:0]  cur_en, cur_dp, cur_bl;

    // Model state.
    int          pos;
    logic [31:0] sh_dig, act_dig;
    logic [7:0]  sh_en, act_en, sh_dp, act_dp, sh_bl, act_bl;
    logic [7:0]  exp_seg, exp_an;
    logic        exp_fd;
    logic [7:0]  seg_tab [16];

    seg_scan_driver #(
        .CLK_HZ     (CLK_HZ),
        .SLOT_HZ    (SLOT_HZ),
        .NUM_DIGITS (NUM_DIGITS),
        .GUARD_CYC  (GUARD_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .digits     (digits),
        .dig_en     (dig_en),
        .dp_en      (dp_en),
`ifdef SEG_SCAN_BLINK_EN
        .blink_en   (blink_en),
`endif
        .seg_out    (seg_out),
        .an_out     (an_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at t=%0t: got %h, expected %h", tag, $time, observed, expected);
        end
    endtask

    // Reference model for one clock edge. It works from the absolute cycle
    // position since reset: the output shows the position just before the edge.
    task automatic modelEdge();
        int  p, slot_cnt, digit, frame;
        bit  phase, lit;
        if (rst) begin
            pos = 0;
            sh_dig = '0; sh_en = '0; sh_dp = '0; sh_bl = '0;
            act_dig = '0; act_en = '0; act_dp = '0; act_bl = '0;
            exp_seg = 8'h00; exp_an = 8'h00; exp_fd = 1'b0;
        end else begin
            p        = pos;
            slot_cnt = p % DIV;
            digit    = (p / DIV) % NUM_DIGITS;
            frame    = p / FRAME;
            phase    = ((frame / 256) % 2) == 1;
            lit      = (slot_cnt >= GUARD_CYC) && act_en[digit]
                       && !(BLINK_BUILD && phase && act_bl[digit]);
            exp_an   = lit ? 8'(1 << digit) : 8'h00;
            exp_seg  = lit ? (seg_tab[act_dig[digit*4 +: 4]] | {7'b0, act_dp[digit]}) : 8'h00;
            if (p % FRAME == FRAME - 1) begin
                act_dig = load ? digits   : sh_dig;
                act_en  = load ? dig_en   : sh_en;
                act_dp  = load ? dp_en    : sh_dp;
                act_bl  = load ? blink_en : sh_bl;
            end
            if (load) begin
                sh_dig = digits; sh_en = dig_en; sh_dp = dp_en; sh_bl = blink_en;
            end
            pos    = p + 1;
            exp_fd = (pos % FRAME) == FRAME - 1;
        end
    endtask

    // Drive one cycle, update the model at the edge, then check the outputs 1ns later.
    task automatic applyStimulus(input logic r, input logic ld);
        rst      = r;
        load     = ld;
        digits   = cur_dig;
        dig_en   = cur_en;
        dp_en    = cur_dp;
        blink_en = cur_bl;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("an_out", an_out, exp_an);
        checkOutput("seg_out", seg_out, exp_seg);
        checkOutput("frame_done", {7'b0, frame_done}, {7'b0, exp_fd});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
    endtask

    task automatic loadValues(input logic [31:0] d, input logic [7:0] en,
                              input logic [7:0] dp, input logic [7:0] bl);
        cur_dig = d; cur_en = en; cur_dp = dp; cur_bl = bl;
        applyStimulus(1'b0, 1'b1);
    endtask

    // Run idle cycles until the model position within the frame equals the
    // target. The wait is bounded, and running out of cycles counts as a failure.
    task automatic waitPos(input int target);
        int guard;
        guard = 0;
        do begin
            applyStimulus(1'b0, 1'b0);
            guard++;
        end while ((pos % FRAME) != target && guard < 2 * FRAME);
        if ((pos % FRAME) != target) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL wait_pos_%0d: position %0d, required %0d", target, pos % FRAME, target);
        end
    endtask

    initial begin
        seg_tab = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                    8'hFE, 8'hE6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
        cur_dig = '0; cur_en = '0; cur_dp = '0; cur_bl = '0;

        // 1: reset for 3 cycles, then a dark frame with periodic frame_done
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("reset_an", an_out, 8'h00);
        checkOutput("reset_seg", seg_out, 8'h00);
        idle(FRAME + 5);
        waitPos(FRAME - 1);
        checkOutput("fd_pulse", {7'b0, frame_done}, 8'h01);
        idle(FRAME);

        // 2: basic digits
        loadValues(32'h76543210, 8'hFF, 8'h00, 8'h00);
        waitPos(0);
        waitPos(3);
        checkOutput("t2_slot0_an", an_out, 8'h01);
        checkOutput("t2_slot0_seg", seg_out, 8'hFC);
        waitPos(51);
        checkOutput("t2_guard_an", an_out, 8'h00);
        waitPos(56);
        checkOutput("t2_slot5_an", an_out, 8'h20);
        checkOutput("t2_slot5_seg", seg_out, 8'hB6);

        // 3: upper hex digits and decimal point on digit 0
        loadValues(32'hFEDCBA98, 8'hFF, 8'h01, 8'h00);
        waitPos(0);
        waitPos(3);
        checkOutput("t3_dp_seg", seg_out, 8'hFF);
        waitPos(23);
        checkOutput("t3_A_seg", seg_out, 8'hEE);
        waitPos(73);
        checkOutput("t3_F_seg", seg_out, 8'h8E);

        // 4: only upper four digits enabled
        loadValues(32'hFEDCBA98, 8'hF0, 8'h00, 8'h00);
        waitPos(0);
        waitPos(3);
        checkOutput("t4_off_an", an_out, 8'h00);
        checkOutput("t4_off_seg", seg_out, 8'h00);
        waitPos(43);
        checkOutput("t4_slot4_an", an_out, 8'h10);
        checkOutput("t4_slot4_seg", seg_out, 8'h9C);

        // 5: mid-frame load stays hidden until the next frame; frame_done-cycle load
        loadValues(32'h76543210, 8'hFF, 8'h00, 8'h00);
        waitPos(0);
        waitPos(30);
        loadValues(32'h01234567, 8'hFF, 8'h00, 8'h00);
        waitPos(36);
        checkOutput("t5_old3_seg", seg_out, 8'hF2);
        waitPos(76);
        checkOutput("t5_old7_seg", seg_out, 8'hE0);
        waitPos(3);
        checkOutput("t5_new0_seg", seg_out, 8'hE0);
        waitPos(FRAME - 1);
        loadValues(32'h89ABCDEF, 8'hFF, 8'h00, 8'h00);
        waitPos(3);
        checkOutput("t5_fdload_seg", seg_out, 8'h8E);

        // 6: reset mid-slot discards a pending load
        waitPos(40);
        loadValues(32'hAAAAAAAA, 8'hFF, 8'hFF, 8'h00);
        waitPos(46);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t6_rst_an", an_out, 8'h00);
        checkOutput("t6_rst_seg", seg_out, 8'h00);
        waitPos(3);
        checkOutput("t6_dark_an", an_out, 8'h00);
        idle(2 * FRAME);

        // Randomized loads and occasional resets
        for (int it = 0; it < 40; it++) begin
            idle($urandom_range(1, 120));
            if ($urandom_range(0, 7) == 0) begin
                applyStimulus(1'b1, 1'b0);
            end
            loadValues($urandom, 8'($urandom), 8'($urandom), 8'($urandom));
        end
        idle(2 * FRAME);

`ifdef SEG_SCAN_BLINK_EN
        // Blink: digit 0 is dark during frames 256-511
        applyStimulus(1'b1, 1'b0);
        loadValues(32'h76543210, 8'hFF, 8'h00, 8'h01);
        idle(520 * FRAME);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
